// File: rtl/obi_pkg.sv
// obi_pkg: shared constants and types for the OBI traffic generator.
// Holds the LFSR feedback polynomial and the generator state encoding.
package obi_pkg;

    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } tg_state_e;

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: common synchronous FIFO, first-word-registered (no fall-through).
// Ports: clk_i, rst_ni (async, active-low), push_i/data_i, pop_i/data_o, empty_o.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]         r_rd;
    logic [AW-1:0]         r_wr;
    logic [AW:0]           r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_push;
    logic                  w_pop;

    assign w_push  = push_i & (r_cnt != (AW+1)'(DEPTH));
    assign w_pop   = pop_i & (r_cnt != '0);
    assign empty_o = (r_cnt == '0);
    assign data_o  = r_mem[r_rd];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr] <= data_i;
    end

endmodule

// File: rtl/obi_tg_lfsr.sv
// obi_tg_lfsr: right-shifting Galois LFSR with synchronous reload to Seed.
// Ports: clk, rst_n (async, active-high), i_load, i_en, o_state.
module obi_tg_lfsr
    import obi_pkg::*;
#(
    parameter int unsigned      Width = 32,
    parameter logic [Width-1:0] Seed  = Width'(32'hACE1_0001),
    parameter logic [Width-1:0] Poly  = Width'(LfsrPoly)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    output logic [Width-1:0] o_state
);

    logic [Width-1:0] r_state;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            r_state <= Seed;
        else if (i_load)
            r_state <= Seed;
        else if (i_en)
            r_state <= (r_state >> 1) ^ (r_state[0] ? Poly : '0);
    end

    assign o_state = r_state;

endmodule

// File: rtl/obi_traffic_gen.sv
// obi_traffic_gen: OBI manager issuing N writes then N read-backs, checking
// responses in order against regenerated IDs and LFSR data.
// Ports: clk, rst_n (async, active-high); start_i/num_req_i/base_addr_i
// control; req/gnt/addr/we/be/wdata/aid request side; rvalid/rdata/rid/err
// response side; busy_o, done_o, mismatch_cnt_o, outstanding_o status.
module obi_traffic_gen
    import obi_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IdWidth     = 5,
    parameter int unsigned NumMaxTrans = 8,
    parameter int unsigned CntWidth    = 16,
    parameter logic [31:0] Seed        = 32'hACE1_0001,
    parameter int unsigned StrideLog2  = 2,
    localparam int unsigned OutW       = $clog2(NumMaxTrans) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [CntWidth-1:0]    num_req_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   we_o,
    output logic [DataWidth/8-1:0] be_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [IdWidth-1:0]     aid_o,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i,
    input  logic [IdWidth-1:0]     rid_i,
    input  logic                   err_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CntWidth-1:0]    mismatch_cnt_o,
    output logic [OutW-1:0]        outstanding_o
);

    localparam int unsigned Rep   = DataWidth / 32;
    localparam int unsigned FifoW = IdWidth + 1;

    tg_state_e            r_state;
    tg_state_e            w_state_nxt;
    logic [CntWidth-1:0]  r_k;
    logic [CntWidth-1:0]  r_num;
    logic [CntWidth-1:0]  r_mis;
    logic [AddrWidth-1:0] r_base;
    logic [OutW-1:0]      r_out;

    logic                 w_active;
    logic                 w_start;
    logic                 w_room;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_wr_last;
    logic                 w_rsp;
    logic                 w_viol;
    logic                 w_bad;
    logic [31:0]          w_gen;
    logic [31:0]          w_chk;
    logic [FifoW-1:0]     w_exp;
    logic                 w_fifo_empty;
    logic                 w_rst_ni;
    logic [AddrWidth-1:0] w_addr;

    assign w_active  = (r_state == WRITE) | (r_state == READ) |
                       (r_state == DRAIN);
    assign w_start   = start_i & ((r_state == IDLE) | (r_state == DONE));
    assign w_room    = (r_num != '0) & (r_out < OutW'(NumMaxTrans));
    assign w_hs      = req_o & gnt_i;
    assign w_last    = (r_k == r_num - 1'b1);
    assign w_wr_last = (r_state == WRITE) & w_hs & w_last;

    // Responses only count while a run is active; stale ones after a
    // reset land in IDLE and are dropped.
    assign w_rsp  = w_active & rvalid_i & ~w_fifo_empty;
    assign w_viol = w_active & rvalid_i & w_fifo_empty;
    assign w_bad  = w_viol |
                    (w_rsp & ((rid_i != w_exp[IdWidth:1]) | err_i |
                              (~w_exp[0] & (rdata_i != {Rep{w_chk}}))));

    assign w_addr = r_base + (AddrWidth'(r_k) << StrideLog2);

    // FSM: state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE:
                if (start_i) w_state_nxt = WRITE;
            WRITE:
                if (r_num == '0)
                    w_state_nxt = DONE;
                else if (w_hs && w_last)
                    w_state_nxt = READ;
            READ:
                if (w_hs && w_last) w_state_nxt = DRAIN;
            DRAIN:
                if (r_out == '0) w_state_nxt = DONE;
            default:
                w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        req_o  = 1'b0;
        we_o   = 1'b0;
        unique case (r_state)
            WRITE: begin
                busy_o = 1'b1;
                req_o  = w_room;
                we_o   = w_room;
            end
            READ: begin
                busy_o = 1'b1;
                req_o  = w_room;
            end
            DRAIN: busy_o = 1'b1;
            DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Payload is zero whenever no request is presented.
    assign addr_o  = req_o ? w_addr : '0;
    assign aid_o   = req_o ? r_k[IdWidth-1:0] : '0;
    assign wdata_o = we_o ? {Rep{w_gen}} : '0;
    assign be_o    = '1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_k    <= '0;
            r_num  <= '0;
            r_base <= '0;
            r_out  <= '0;
            r_mis  <= '0;
        end else begin
            if (w_start) begin
                r_k    <= '0;
                r_num  <= num_req_i;
                r_base <= base_addr_i;
            end else if (w_hs) begin
                r_k <= w_last ? '0 : r_k + 1'b1;
            end
            r_out <= r_out + OutW'(w_hs) - OutW'(w_rsp);
            if (w_start)
                r_mis <= '0;
            else if (w_bad && (r_mis != '1))
                r_mis <= r_mis + 1'b1;
        end
    end

    assign mismatch_cnt_o = r_mis;
    assign outstanding_o  = r_out;

    obi_tg_lfsr #(
        .Width (32),
        .Seed  (Seed)
    ) u_gen_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_start | w_wr_last),
        .i_en    (w_hs),
        .o_state (w_gen)
    );

    obi_tg_lfsr #(
        .Width (32),
        .Seed  (Seed)
    ) u_chk_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_start | w_wr_last),
        .i_en    (w_rsp & ~w_exp[0]),
        .o_state (w_chk)
    );

    assign w_rst_ni = ~rst_n;

    // Entry = {id, we}; responses return in issue order.
    fifo_v3 #(
        .DATA_WIDTH (FifoW),
        .DEPTH      (NumMaxTrans)
    ) u_id_fifo (
        .clk_i   (clk),
        .rst_ni  (w_rst_ni),
        .push_i  (w_hs),
        .data_i  ({aid_o, we_o}),
        .pop_i   (w_rsp),
        .data_o  (w_exp),
        .empty_o (w_fifo_empty)
    );

endmodule

// File: tb/tb_obi_traffic_gen.sv
// tb_obi_traffic_gen: directed bench with an OBI subordinate model and a
// transaction-level reference checked every cycle.
module tb_obi_traffic_gen;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] num_req_i;
    logic [31:0] base_addr_i;
    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic [4:0]  aid_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic [4:0]  rid_i;
    logic        err_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] mismatch_cnt_o;
    logic [3:0]  outstanding_o;

    obi_traffic_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .num_req_i      (num_req_i),
        .base_addr_i    (base_addr_i),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .addr_o         (addr_o),
        .we_o           (we_o),
        .be_o           (be_o),
        .wdata_o        (wdata_o),
        .aid_o          (aid_o),
        .rvalid_i       (rvalid_i),
        .rdata_i        (rdata_i),
        .rid_i          (rid_i),
        .err_i          (err_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mismatch_cnt_o (mismatch_cnt_o),
        .outstanding_o  (outstanding_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Transaction-level reference: writes 0..N-1 then reads N..2N-1.
    logic [31:0] t_addr  [64];
    logic [31:0] t_wdata [64];
    logic [4:0]  t_aid   [64];
    bit          t_we    [64];
    int          n_tx    = 0;
    bit          active  = 0;
    bit          m_done  = 0;
    int          m_out   = 0;
    int          m_mis   = 0;
    int          issued  = 0;
    int          grants  = 0;
    int          pq [$];
    logic [31:0] obs_addr  [$];
    logic [31:0] obs_wdata [$];
    logic [31:0] mem [logic [31:0]];

    bit gnt_en       = 1;
    bit rsp_en       = 1;
    bit rid_plus1    = 0;
    bit inject_stale = 0;
    int bad_rd       = -1;
    int bad_wr       = -1;

    bit          exp_req, nxt_done, hs, rsp, bad;
    int          idx;
    logic [4:0]  r_id;
    logic [31:0] r_dat;
    logic        r_err;
    logic [31:0] lf;

    // Subordinate + compare process, all on the falling edge.
    initial begin : resp_proc
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rid_i    = '0;
        err_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rst_req", req_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_out", outstanding_o, 0);
                chk("rst_mis", mismatch_cnt_o, 0);
                chk("rst_addr", addr_o, 0);
                chk("rst_wdata", wdata_o, 0);
                chk("rst_be", be_o, 4'hF);
                active = 0;
                m_done = 0;
                m_out  = 0;
                m_mis  = 0;
                issued = 0;
                pq.delete();
                gnt_i    = 1'b0;
                rvalid_i = 1'b0;
                err_i    = 1'b0;
            end else begin
                exp_req = active && issued < 2 * n_tx && m_out < 8;
                chk("req", req_o, exp_req);
                chk("busy", busy_o, active && !m_done);
                chk("done", done_o, m_done);
                chk("out", outstanding_o, m_out);
                chk("mis", mismatch_cnt_o, m_mis);
                if (req_o && exp_req) begin
                    chk("addr", addr_o, t_addr[issued]);
                    chk("we", we_o, t_we[issued]);
                    chk("aid", aid_o, t_aid[issued]);
                    if (t_we[issued])
                        chk("wdata", wdata_o, t_wdata[issued]);
                end
                nxt_done = m_done ||
                           (active && issued == 2 * n_tx && m_out == 0);
                rsp = 0;
                bad = 0;
                if (inject_stale) begin
                    rvalid_i     = 1'b1;
                    rid_i        = 5'd3;
                    err_i        = 1'b0;
                    rdata_i      = $urandom;
                    inject_stale = 0;
                end else if (rsp_en && pq.size() != 0) begin
                    idx   = pq.pop_front();
                    rsp   = 1;
                    r_id  = t_aid[idx] + (rid_plus1 ? 5'd1 : 5'd0);
                    r_err = t_we[idx] && idx == bad_wr;
                    if (t_we[idx]) begin
                        r_dat = $urandom;
                    end else begin
                        r_dat = mem[t_addr[idx]];
                        if (idx - n_tx == bad_rd)
                            r_dat = r_dat ^ 32'h1;
                    end
                    bad = (r_id != t_aid[idx]) || r_err ||
                          (!t_we[idx] && r_dat != t_wdata[idx]);
                    rvalid_i = 1'b1;
                    rid_i    = r_id;
                    err_i    = r_err;
                    rdata_i  = r_dat;
                end else begin
                    rvalid_i = 1'b0;
                    rid_i    = '0;
                    err_i    = 1'b0;
                    rdata_i  = '0;
                end
                gnt_i = gnt_en;
                hs = req_o && gnt_i && issued < 2 * n_tx;
                if (hs) begin
                    grants++;
                    obs_addr.push_back(addr_o);
                    obs_wdata.push_back(wdata_o);
                    if (we_o)
                        mem[addr_o] = wdata_o;
                    pq.push_back(issued);
                    issued++;
                end
                m_out  = m_out + int'(hs) - int'(rsp);
                if (bad)
                    m_mis++;
                m_done = nxt_done;
                if (start_i && (!active || m_done)) begin
                    n_tx = num_req_i;
                    lf   = SEED;
                    for (int k = 0; k < n_tx; k++) begin
                        t_addr[k]         = base_addr_i + k * 4;
                        t_we[k]           = 1;
                        t_aid[k]          = k[4:0];
                        t_wdata[k]        = lf;
                        t_addr[k + n_tx]  = t_addr[k];
                        t_we[k + n_tx]    = 0;
                        t_aid[k + n_tx]   = k[4:0];
                        t_wdata[k + n_tx] = lf;
                        lf = lfsr_step(lf);
                    end
                    active = 1;
                    m_done = 0;
                    m_mis  = 0;
                    issued = 0;
                    grants = 0;
                    obs_addr.delete();
                    obs_wdata.delete();
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] n, input logic [31:0] b);
        @(posedge clk); #1;
        num_req_i   = n;
        base_addr_i = b;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_reached", done_o, 1);
    endtask

    task automatic run(input logic [15:0] n, input logic [31:0] b,
                       output int cyc);
        pulse_start(n, b);
        wait_done(cyc);
    endtask

    int cyc;
    int w;

    initial begin : stim
        rst_n       = 1'b1;
        start_i     = 1'b0;
        num_req_i   = '0;
        base_addr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // Always-grant, next-cycle responses.
        run(16, 32'h1000, cyc);
        chk("n16_cycles_ok", (cyc >= 32 && cyc <= 36), 1);
        chk("n16_grants", grants, 32);
        chk("n16_mis", mismatch_cnt_o, 0);
        chk("n16_addr0", obs_addr[0], 32'h1000);
        chk("n16_addr15", obs_addr[15], 32'h103C);
        chk("n16_rdaddr0", obs_addr[16], 32'h1000);
        chk("n16_wd0", obs_wdata[0], 32'hACE1_0001);
        chk("n16_wd1", obs_wdata[1], 32'hD650_8003);
        chk("n16_wd2", obs_wdata[2], 32'hEB08_4002);

        // Responses withheld: issue stops at the outstanding limit.
        rsp_en = 0;
        pulse_start(16, 32'h2000);
        repeat (20) @(posedge clk);
        #1;
        chk("held_grants", grants, 8);
        chk("held_out", outstanding_o, 8);
        rsp_en = 1;
        wait_done(cyc);
        chk("held_mis", mismatch_cnt_o, 0);
        chk("held_grants_all", grants, 32);

        // One bad read datum and one write error.
        bad_rd = 3;
        bad_wr = 5;
        run(10, 32'h4000, cyc);
        chk("corrupt_mis", mismatch_cnt_o, 2);
        bad_rd = -1;
        bad_wr = -1;

        // Every response carries the wrong ID.
        rid_plus1 = 1;
        run(4, 32'h5000, cyc);
        chk("rid_mis", mismatch_cnt_o, 8);
        rid_plus1 = 0;

        // Address wrap at the top of the space.
        run(4, 32'hFFFF_FFF8, cyc);
        chk("wrap_a0", obs_addr[0], 32'hFFFF_FFF8);
        chk("wrap_a1", obs_addr[1], 32'hFFFF_FFFC);
        chk("wrap_a2", obs_addr[2], 32'h0000_0000);
        chk("wrap_a3", obs_addr[3], 32'h0000_0004);
        chk("wrap_mis", mismatch_cnt_o, 0);

        // Zero-count start.
        run(0, 32'h6000, cyc);
        chk("zero_cyc", cyc, 1);
        chk("zero_grants", grants, 0);

        // Reset in the middle of the read phase.
        pulse_start(16, 32'h7000);
        w = 0;
        while (grants < 20 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("midrd_reached", (grants >= 20), 1);
        rst_n = 1'b1;
        #1;
        chk("midrd_req", req_o, 0);
        chk("midrd_busy", busy_o, 0);
        chk("midrd_out", outstanding_o, 0);
        chk("midrd_addr", addr_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        inject_stale = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("stale_mis", mismatch_cnt_o, 0);
        chk("stale_out", outstanding_o, 0);

        run(16, 32'h3000, cyc);
        chk("rerun_mis", mismatch_cnt_o, 0);
        chk("rerun_grants", grants, 32);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/obi_traffic_gen.md
Name: obi_traffic_gen

Overview:
- Synthesizable OBI manager traffic generator and self-checker. It replaces the behavioural random manager in benches and on-chip BIST of OBI and relOBI crossbars.
- Issues a configurable number of writes followed by read-back of the same addresses. Tracks outstanding transactions and checks read data and response IDs against regenerated expectations.
- Sits in front of a relobi_encoder on any crossbar manager port.

Parameters:
- AddrWidth, 32, OBI address width
- DataWidth, 32, OBI data width; multiple of 32
- IdWidth, 5, OBI aid/rid width
- NumMaxTrans, 8, maximum outstanding transactions; power of two, ≥2
- CntWidth, 16, width of request counter and count input
- Seed, 32'hACE1_0001, nonzero LFSR seed
- StrideLog2, 2, address stride = 2^StrideLog2 bytes

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle start pulse; accepted only in IDLE or DONE
- num_req_i  in  CntWidth  transactions per phase; sampled on accepted start
- base_addr_i  in  AddrWidth  first address; sampled on accepted start
- req_o  out  1  OBI request
- gnt_i  in  1  OBI grant
- addr_o  out  AddrWidth  OBI address
- we_o  out  1  OBI write enable
- be_o  out  DataWidth/8  byte enables; always all ones
- wdata_o  out  DataWidth  write data
- aid_o  out  IdWidth  request ID
- rvalid_i  in  1  response valid; rready is not used
- rdata_i  in  DataWidth  read data
- rid_i  in  IdWidth  response ID
- err_i  in  1  response error
- busy_o  out  1  high in WRITE, READ and DRAIN
- done_o  out  1  high in DONE
- mismatch_cnt_o  out  CntWidth  data/ID/error mismatches; saturating
- outstanding_o  out  $clog2(NumMaxTrans)+1  current outstanding count

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except be_o, which is all ones.
  - LFSR = Seed; counters = 0.
- Reset asserted mid-operation aborts immediately. In-flight responses arriving after reset release are ignored because state is IDLE.
- States and transitions:
  - IDLE/DONE → WRITE on start_i. Latch num_req_i and base_addr_i. Clear mismatch_cnt_o. Reload LFSR = Seed.
  - If the latched count is 0, go directly to DONE one cycle later.
  - WRITE: issue writes k = 0..N-1.
    - addr = base + (k << StrideLog2), wrap modulo 2^AddrWidth.
    - wdata = current LFSR value, replicated DataWidth/32 times.
    - aid = k[IdWidth-1:0].
    - On the last write handshake → READ, with the LFSR reloaded to Seed and k = 0.
  - READ: issue reads to the same addresses and IDs. On the last read handshake → DRAIN.
  - DRAIN: wait until outstanding = 0 → DONE.
  - DONE holds until the next start_i. start_i in WRITE/READ/DRAIN is ignored.
- Handshake:
  - req_o is raised only if outstanding < NumMaxTrans.
  - Once raised, req_o and its payload stay stable until gnt_i. There is no retraction.
  - Handshake = req_o & gnt_i. After a grant, the next request may be presented the following cycle. Throughput is 1/cycle.
- Outstanding counter:
  - Next value = current + handshake − rvalid_i; a simultaneous grant and response leave it unchanged.
  - rvalid_i with outstanding = 0 is a protocol violation: increment mismatch_cnt_o and leave the counter unchanged.
- Expected-ID FIFO:
  - Depth NumMaxTrans, holds {IdWidth id, 1-bit we}.
  - Pushed on handshake, popped on rvalid_i. Responses are in order.
- Checks on each response; each mismatching response increments mismatch_cnt_o by 1, saturating at all ones:
  - rid_i ≠ FIFO id.
  - err_i = 1.
  - Read response with rdata_i ≠ check-LFSR value, replicated.
- Check-LFSR:
  - A separate instance, reloaded to Seed on entering READ.
  - Advances on each read response.
  - Write responses do not compare data and do not advance it.
- LFSR:
  - 32-bit Galois, taps 0x8020_0003, shift right.
  - The write/read generator advances on each handshake.
- Counter k is CntWidth bits; N = 2^CntWidth − 1 is legal.

Decomposition:
- obi_pkg: the LFSR polynomial constant and a state enum typedef (IDLE, WRITE, READ, DRAIN, DONE).
- Sub-module obi_tg_lfsr (width 32, Seed, load/enable inputs), instantiated twice: once for generation, once for checking.
- The expected-ID FIFO uses the existing common fifo_v3.

Test Plan:
- Zero-latency subordinate, always granting, rvalid the cycle after grant. start with N=16, base 0x1000 → 16 writes to 0x1000..0x103C, then 16 reads; done_o after 34±2 cycles; mismatch_cnt_o = 0.
- Subordinate withholding all rvalid:
  - Exactly 8 grants, then req_o stays high with stable payload and outstanding_o = 8.
  - Releasing responses resumes issue.
- Subordinate corrupting rdata bit 0 on read #3 and returning err on write #5, N=10 → mismatch_cnt_o = 2.
- Subordinate returning rid+1 on all responses, N=4 → mismatch_cnt_o = 8.
- Base 0xFFFF_FFF8, N=4 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4 (wrap).
- Zero-count start and reset mid-operation:
  - N=0 → done_o one cycle later, no req_o.
  - Reset asserted mid-READ → all outputs at reset values.
  - A second start → a full clean run with mismatch_cnt_o = 0.
